// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB master among NUM_REQ requesters.
// Define AHB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module ahb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      resp_done,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic                    busy,
  output logic [IDXW-1:0]         grant_idx,
  output logic                    m_request_write,
  output logic                    m_request_read,
  output logic [31:0]             m_write_addr,
  output logic [31:0]             m_read_addr,
  output logic [31:0]             m_write_data,
  input  logic [1:0]              m_htrans,
  input  logic                    m_hready,
  input  logic [1:0]              m_hresp,
  input  logic [31:0]             m_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic                any_req;
  logic [IDXW-1:0]     win;
  logic [NUM_REQ-1:0]  win_oh;
  logic                win_write;
  logic [31:0]         win_addr;
  logic [31:0]         win_wdata;
  logic [IDXW:0]       cand;
  logic                complete;
  logic [NUM_REQ-1:0]  sel_oh;
  logic                wr;
  logic                err;

`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0]     ptr;
`endif

  assign complete = (m_htrans == 2'b10) && m_hready;

  // Search order starts at the pointer (or at 0 for fixed priority) and wraps.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
      cand = (IDXW+1)'(k);
`else
      cand = {1'b0, ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NUM_REQ)) cand = cand - (IDXW+1)'(NUM_REQ);
`endif
      if (!any_req && req_valid[cand[IDXW-1:0]]) begin
        any_req = 1'b1;
        win     = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    win_oh    = '0;
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (any_req && (win == IDXW'(i))) begin
        win_oh[i] = 1'b1;
        win_write = req_write[i];
        win_addr  = req_addr[32*i +: 32];
        win_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_req) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (complete) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      gnt             <= '0;
      resp_done       <= '0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      busy            <= 1'b0;
      grant_idx       <= '0;
      m_request_write <= 1'b0;
      m_request_read  <= 1'b0;
      m_write_addr    <= '0;
      m_read_addr     <= '0;
      m_write_data    <= '0;
      sel_oh          <= '0;
      wr              <= 1'b0;
      err             <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      ptr             <= '0;
`endif
    end else begin
      gnt             <= '0;
      resp_done       <= '0;
      m_request_write <= 1'b0;
      m_request_read  <= 1'b0;
      busy            <= (next_state != S_IDLE);
      case (state)
        S_IDLE: begin
          // Pulses are registered here so they appear during the ISSUE cycle.
          if (any_req) begin
            grant_idx       <= win;
            sel_oh          <= win_oh;
            wr              <= win_write;
            m_write_addr    <= win_addr;
            m_read_addr     <= win_addr;
            m_write_data    <= win_wdata;
            gnt             <= win_oh;
            m_request_write <= win_write;
            m_request_read  <= !win_write;
          end
        end
        S_WAIT: begin
          if (complete) err <= (m_hresp != 2'b00);
        end
        S_DONE: begin
          resp_done <= sel_oh;
          resp_err  <= err;
          if (!wr) resp_rdata <= m_read_data;
`ifndef AHB_ARB_FIXED_PRIO_EN
          if (grant_idx == IDXW'(NUM_REQ-1)) ptr <= '0;
          else                               ptr <= grant_idx + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: directed cases plus randomized transactions
// checked against a transaction-level arbitration model.
module tb_ahb_master_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDXW    = 2;

  logic                  HCLK = 1'b0;
  logic                  HRESET;
  logic [NUM_REQ-1:0]    req_valid, req_write;
  logic [32*NUM_REQ-1:0] req_addr, req_wdata;
  logic [NUM_REQ-1:0]    gnt, resp_done;
  logic [31:0]           resp_rdata;
  logic                  resp_err, busy;
  logic [IDXW-1:0]       grant_idx;
  logic                  m_request_write, m_request_read;
  logic [31:0]           m_write_addr, m_read_addr, m_write_data;
  logic [1:0]            m_htrans;
  logic                  m_hready;
  logic [1:0]            m_hresp;
  logic [31:0]           m_read_data;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .grant_idx(grant_idx),
    .m_request_write(m_request_write), .m_request_read(m_request_read),
    .m_write_addr(m_write_addr), .m_read_addr(m_read_addr), .m_write_data(m_write_data),
    .m_htrans(m_htrans), .m_hready(m_hready), .m_hresp(m_hresp), .m_read_data(m_read_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]        a_addr[NUM_REQ];
  logic [31:0]        a_wdata[NUM_REQ];
  logic [NUM_REQ-1:0] a_write;
  int                 ptr_m;
  logic [31:0]        last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_reqs(input logic [NUM_REQ-1:0] vld);
    req_valid = vld;
    req_write = a_write;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[32*i +: 32]  = a_addr[i];
      req_wdata[32*i +: 32] = a_wdata[i];
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] vld);
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
      int i = k;
`else
      int i = (ptr_m + k) % NUM_REQ;
`endif
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt), 32'd0);
    check({tag, "_done"},  32'(resp_done), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_err"},   32'(resp_err), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_idx"},   32'(grant_idx), 32'd0);
    check({tag, "_pulses"}, 32'({m_request_write, m_request_read}), 32'd0);
    check({tag, "_fields"}, m_write_addr | m_read_addr | m_write_data, 32'd0);
  endtask

  // One complete transaction: grant, wait states, completion, response.
  task automatic txn(input logic [NUM_REQ-1:0] vld_in, input bit hold, input int waits,
                     input logic [1:0] hresp, input logic [31:0] rdata);
    logic [NUM_REQ-1:0] vld, oh;
    logic [31:0]        exp_addr, exp_wdata, exp_rdata;
    logic               exp_wr;
    int                 w, r;
    vld = vld_in;
    w = pick(vld);
    oh = '0;
    oh[w] = 1'b1;
    exp_addr  = a_addr[w];
    exp_wdata = a_wdata[w];
    exp_wr    = a_write[w];
    drive_reqs(vld);
    m_htrans = 2'b00; m_hready = 1'b1; m_hresp = 2'b00;
    tick;
    check("gnt", 32'(gnt), 32'(oh));
    check("grant_idx", 32'(grant_idx), 32'(w));
    check("busy_issue", 32'(busy), 32'd1);
    check("done_issue", 32'(resp_done), 32'd0);
    check("wr_pulse", 32'(m_request_write), 32'(exp_wr));
    check("rd_pulse", 32'(m_request_read), 32'(!exp_wr));
    check("m_write_addr", m_write_addr, exp_addr);
    check("m_read_addr", m_read_addr, exp_addr);
    check("m_write_data", m_write_data, exp_wdata);
    if (!hold) begin
      vld[w] = 1'b0;
      a_addr[w]  = $urandom;
      a_wdata[w] = $urandom;
      a_write[w] = ~a_write[w];
      drive_reqs(vld);
    end
    tick;
    check("gnt_wait", 32'(gnt), 32'd0);
    check("pulses_wait", 32'({m_request_write, m_request_read}), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
    for (int c = 0; c < waits; c++) begin
      r = int'($urandom_range(0, 2));
      if (r == 0)      begin m_htrans = 2'b10; m_hready = 1'b0; end
      else if (r == 1) begin m_htrans = 2'b11; m_hready = 1'b1; end
      else             begin m_htrans = 2'b00; m_hready = 1'b1; end
      m_hresp = 2'($urandom);
      m_read_data = $urandom;
      tick;
      check("busy_ws", 32'(busy), 32'd1);
      check("done_ws", 32'(resp_done), 32'd0);
      check("addr_hold", m_read_addr, exp_addr);
    end
    m_htrans = 2'b10; m_hready = 1'b1; m_hresp = hresp; m_read_data = rdata;
    tick;
    check("busy_done", 32'(busy), 32'd1);
    check("done_early", 32'(resp_done), 32'd0);
    m_htrans = 2'b00;
    m_hresp = ~hresp;
    if (exp_wr) m_read_data = ~rdata;
    tick;
    exp_rdata = exp_wr ? last_rdata : rdata;
    check("resp_done", 32'(resp_done), 32'(oh));
    check("resp_err", 32'(resp_err), 32'(hresp != 2'b00));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("busy_after", 32'(busy), 32'd0);
    last_rdata = exp_rdata;
`ifndef AHB_ARB_FIXED_PRIO_EN
    ptr_m = (w + 1) % NUM_REQ;
`endif
    m_hresp = 2'b00;
  endtask

  initial begin
    HRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    m_htrans = 2'b00; m_hready = 1'b1; m_hresp = 2'b00; m_read_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin a_addr[i] = '0; a_wdata[i] = '0; end
    a_write = '0;
    ptr_m = 0;
    last_rdata = '0;
    #3;
    check_all_zero("reset");
    tick; tick;
    HRESET = 1'b0;

    for (int c = 0; c < 3; c++) begin
      tick;
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Single read
    a_addr[0] = 32'h100; a_write[0] = 1'b0;
    txn(4'b0001, 1'b0, 0, 2'b00, 32'hDEADBEEF);
    // Write with three wait states
    a_addr[2] = 32'h200; a_wdata[2] = 32'hA5A5A5A5; a_write[2] = 1'b1;
    txn(4'b0100, 1'b0, 3, 2'b00, 32'h0);
    // Error read then OKAY read
    a_addr[1] = 32'h140; a_write[1] = 1'b0;
    txn(4'b0010, 1'b0, 1, 2'b01, 32'h12345678);
    a_addr[3] = 32'h180; a_write[3] = 1'b0;
    txn(4'b1000, 1'b0, 0, 2'b00, 32'hCAFEF00D);
    // All requesting continuously
    for (int i = 0; i < NUM_REQ; i++) begin
      a_addr[i] = 32'h1000 + 32'(i); a_wdata[i] = $urandom; a_write[i] = i[0];
    end
    for (int t = 0; t < 5; t++) txn(4'b1111, 1'b1, 0, 2'b00, $urandom);
    // Fixed-priority style pattern
    for (int t = 0; t < 3; t++) txn(4'b1010, 1'b1, 0, 2'b00, $urandom);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        a_addr[i] = $urandom; a_wdata[i] = $urandom; a_write[i] = 1'($urandom);
      end
      txn(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 1'($urandom),
          int'($urandom_range(0, 4)), 2'($urandom), $urandom);
    end

    // Reset during WAIT
    a_addr[2] = 32'h300; a_write[2] = 1'b0;
    drive_reqs(4'b0100);
    tick;
    check("rst_pre_gnt", 32'(gnt), 32'b0100);
    drive_reqs('0);
    tick;
    m_htrans = 2'b10; m_hready = 1'b0;
    tick; tick;
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 HRESET = 1'b1;
    #1;
    check_all_zero("midrst");
    m_hready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      check("rst_hold_done", 32'(resp_done), 32'd0);
      check("rst_hold_busy", 32'(busy), 32'd0);
    end
    HRESET = 1'b0;
    m_htrans = 2'b00;
    ptr_m = 0;
    last_rdata = '0;
    tick;
    check("post_rst_done", 32'(resp_done), 32'd0);
    txn(4'b1111, 1'b1, 0, 2'b00, 32'h0BADCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
